// File: rtl/accel_read_scheduler.sv
// accel_read_scheduler
//   Drives a 3-axis accelerometer through an external SPI master. Once
//   enabled it writes DATA_FORMAT, BW_RATE and POWER_CTL, then on every
//   sample tick reads the six data registers (0x32..0x37) and publishes a
//   complete X/Y/Z sample through a valid/ready handshake.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   enable            level-sensitive run request
//   spi_req           transaction request, held until spi_done
//   spi_rw            1 = read, 0 = write (stable while spi_req)
//   spi_addr          register address (stable while spi_req)
//   spi_wdata         write byte (stable while spi_req)
//   spi_done          one-cycle completion pulse from the SPI master
//   spi_rdata         read byte, valid in the spi_done cycle
//   axis_x/y/z        latest complete sample, two's complement
//   sample_valid      sample available, held until accepted
//   sample_ready      consumer acceptance
//   cfg_done          configuration sequence complete
//   overrun_cnt       saturating count of unaccepted samples overwritten
//   timeout_err       sticky SPI watchdog error
module accel_read_scheduler #(
  parameter int unsigned SAMPLE_DIV = 1000000,
  parameter logic [7:0]  FORMAT_VAL = 8'h0B,
  parameter logic [7:0]  RATE_VAL   = 8'h0A,
  parameter logic [7:0]  POWER_VAL  = 8'h08,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        spi_req,
  output logic        spi_rw,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic        spi_done,
  input  logic [7:0]  spi_rdata,
  output logic [15:0] axis_x,
  output logic [15:0] axis_y,
  output logic [15:0] axis_z,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        cfg_done,
  output logic [7:0]  overrun_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, CFG_FMT, CFG_RATE, CFG_PWR, WAIT_TICK, READ, PUBLISH
  } state_t;

  state_t      state, next_state, adv_state;
  logic        issue_state;
  logic        cmd_rw;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;

  logic [31:0] tick_cnt;
  logic [31:0] wd_cnt;
  logic [2:0]  byte_idx;
  logic [47:0] shadow;
  logic        pending;

  logic        xfer_done;
  logic        wd_expire;
  logic        running;
  logic        tick;

  // A completion only counts while a request is outstanding.
  assign xfer_done = spi_req && spi_done;
  assign wd_expire = spi_req && !spi_done && (wd_cnt == TIMEOUT - 1);
  assign running   = cfg_done && enable;
  assign tick      = running && (tick_cnt == SAMPLE_DIV - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    adv_state   = state;
    issue_state = 1'b0;
    cmd_rw      = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    case (state)
      IDLE:      if (enable) next_state = CFG_FMT;
      CFG_FMT: begin
        issue_state = 1'b1;
        cmd_addr    = 6'h31;
        cmd_wdata   = FORMAT_VAL;
        adv_state   = CFG_RATE;
      end
      CFG_RATE: begin
        issue_state = 1'b1;
        cmd_addr    = 6'h2C;
        cmd_wdata   = RATE_VAL;
        adv_state   = CFG_PWR;
      end
      CFG_PWR: begin
        issue_state = 1'b1;
        cmd_addr    = 6'h2D;
        cmd_wdata   = POWER_VAL;
        adv_state   = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)             next_state = IDLE;
        else if (tick || pending) next_state = READ;
      end
      READ: begin
        issue_state = 1'b1;
        cmd_rw      = 1'b1;
        cmd_addr    = 6'h32 + {3'b000, byte_idx};
        adv_state   = (byte_idx == 3'd5) ? PUBLISH : READ;
      end
      PUBLISH:   next_state = enable ? WAIT_TICK : IDLE;
      default:   next_state = IDLE;
    endcase

    // Shared transaction sequencing for every state that talks to the SPI
    // master: an in-flight transfer always finishes (or times out) before
    // an enable drop takes effect.
    if (issue_state) begin
      if (wd_expire)                next_state = IDLE;
      else if (xfer_done)           next_state = enable ? adv_state : IDLE;
      else if (!spi_req && !enable) next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_req      <= 1'b0;
      spi_rw       <= 1'b0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
      cfg_done     <= 1'b0;
      tick_cnt     <= '0;
      pending      <= 1'b0;
      byte_idx     <= '0;
      shadow       <= '0;
      axis_x       <= '0;
      axis_y       <= '0;
      axis_z       <= '0;
      sample_valid <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      // Request is raised only from a low spi_req, which guarantees at least
      // one idle cycle between consecutive transactions.
      if (spi_req) begin
        if (xfer_done || wd_expire) spi_req <= 1'b0;
      end else if (issue_state && enable) begin
        spi_req   <= 1'b1;
        spi_rw    <= cmd_rw;
        spi_addr  <= cmd_addr;
        spi_wdata <= cmd_wdata;
      end

      if (!spi_req || xfer_done || wd_expire) wd_cnt <= '0;
      else                                    wd_cnt <= wd_cnt + 32'd1;

      if (wd_expire) timeout_err <= 1'b1;

      cfg_done <= (next_state == WAIT_TICK) || (next_state == READ) ||
                  (next_state == PUBLISH);

      if (!running || next_state == IDLE || tick) tick_cnt <= '0;
      else                                         tick_cnt <= tick_cnt + 32'd1;

      if (next_state == IDLE)
        pending <= 1'b0;
      else if (state == WAIT_TICK && next_state == READ)
        pending <= 1'b0;
      else if (tick && (state == READ || state == PUBLISH))
        pending <= 1'b1;

      if (state != READ)  byte_idx <= '0;
      else if (xfer_done) byte_idx <= byte_idx + 3'd1;

      if (next_state == IDLE)
        shadow <= '0;
      else if (state == READ && xfer_done)
        shadow[{byte_idx, 3'b000} +: 8] <= spi_rdata;

      if (state == PUBLISH) begin
        axis_x       <= shadow[15:0];
        axis_y       <= shadow[31:16];
        axis_z       <= shadow[47:32];
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_read_scheduler.sv
// Testbench for accel_read_scheduler: directed scenarios against a simple SPI
// slave model that answers every request 10 cycles after it is seen. Read
// bytes for sample k are {01,02,03,04,05,FF} + k (mod 256) for 0x32..0x37.
module tb_accel_read_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        spi_req;
  logic        spi_rw;
  logic [5:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_done;
  logic [7:0]  spi_rdata;
  logic [15:0] axis_x, axis_y, axis_z;
  logic        sample_valid;
  logic        sample_ready;
  logic        cfg_done;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        model_on = 1'b1;
  int unsigned n37;
  logic [5:0]  log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_rw[$];
  logic [7:0]  rd_base[0:5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};

  accel_read_scheduler #(
    .SAMPLE_DIV(100),
    .FORMAT_VAL(8'h0B),
    .RATE_VAL  (8'h0A),
    .POWER_VAL (8'h08),
    .TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .spi_req     (spi_req),
    .spi_rw      (spi_rw),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_done    (spi_done),
    .spi_rdata   (spi_rdata),
    .axis_x      (axis_x),
    .axis_y      (axis_y),
    .axis_z      (axis_z),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .cfg_done    (cfg_done),
    .overrun_cnt (overrun_cnt),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  // SPI slave model
  initial begin
    int unsigned cnt;
    int          idx;
    cnt       = 0;
    n37       = 0;
    spi_done  = 1'b0;
    spi_rdata = '0;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (rst || !spi_req || !model_on) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 10) begin
          cnt      = 0;
          spi_done = 1'b1;
          if (spi_rw) begin
            idx = int'(spi_addr) - 'h32;
            if (idx >= 0 && idx <= 5) spi_rdata = rd_base[idx] + n37[7:0];
            else                      spi_rdata = 8'h00;
            log_data.push_back(spi_rdata);
          end else begin
            log_data.push_back(spi_wdata);
          end
          log_addr.push_back(spi_addr);
          log_rw.push_back(spi_rw);
          if (spi_rw && spi_addr == 6'h37) n37++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({spi_req, spi_rw, spi_addr, spi_wdata} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_spi: got %h expected 0000", {spi_req, spi_rw, spi_addr, spi_wdata});
    end
    n_checks++;
    if ({axis_x, axis_y, axis_z} !== 48'h0) begin
      n_fail++; $display("FAIL reset_axis: got %h expected 0", {axis_x, axis_y, axis_z});
    end
    n_checks++;
    if ({sample_valid, cfg_done, overrun_cnt, timeout_err} !== 11'h0) begin
      n_fail++; $display("FAIL reset_status: got %h expected 0", {sample_valid, cfg_done, overrun_cnt, timeout_err});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (spi_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_req: got %b expected 0", spi_req);
    end
  endtask

  task automatic test_config();
    logic ok;
    int   base;
    logic [5:0] exp_a[3] = '{6'h31, 6'h2C, 6'h2D};
    logic [7:0] exp_d[3] = '{8'h0B, 8'h0A, 8'h08};
    base = log_addr.size();
    @(negedge clk); enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cfg_done) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cfg_wait: cfg_done got 0 expected 1 within 200 cycles"); end
    n_checks++;
    if (log_addr.size() != base + 3) begin
      n_fail++; $display("FAIL cfg_count: got %0d writes expected 3", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if ({log_rw[base+i], log_addr[base+i], log_data[base+i]} !== {1'b0, exp_a[i], exp_d[i]}) begin
          n_fail++; $display("FAIL cfg_write%0d: got rw=%b addr=%h data=%h expected rw=0 addr=%h data=%h",
                             i, log_rw[base+i], log_addr[base+i], log_data[base+i], exp_a[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_sample();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sample_wait: sample_valid got 0 expected 1 within 400 cycles"); end
    n_checks++;
    if ({axis_x, axis_y, axis_z} !== {16'h0201, 16'h0403, 16'hFF05}) begin
      n_fail++; $display("FAIL sample0_axes: got %h %h %h expected 0201 0403 ff05", axis_x, axis_y, axis_z);
    end
    n_checks++;
    ok = (log_addr.size() == 9);
    for (int i = 0; i < 6 && ok; i++)
      if (log_rw[3+i] !== 1'b1 || log_addr[3+i] !== 6'h32 + 6'(i)) ok = 1'b0;
    if (!ok) begin n_fail++; $display("FAIL read_order: got %0d entries expected reads 32..37 in order", log_addr.size()); end
  endtask

  task automatic test_overrun();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (overrun_cnt == 8'd2) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overrun_wait: overrun_cnt got %0d expected 2", overrun_cnt); end
    n_checks++;
    if ({axis_x, axis_y, axis_z, sample_valid} !== {16'h0403, 16'h0605, 16'h0107, 1'b1}) begin
      n_fail++; $display("FAIL sample2_axes: got %h %h %h v=%b expected 0403 0605 0107 v=1", axis_x, axis_y, axis_z, sample_valid);
    end
    @(negedge clk); sample_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL valid_clear: got %b expected 0", sample_valid); end
    @(negedge clk); sample_ready = 1'b0;
    n_checks++;
    if (overrun_cnt !== 8'd2) begin n_fail++; $display("FAIL overrun_hold: got %0d expected 2", overrun_cnt); end
  endtask

  task automatic test_accept_same_cycle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sample_valid) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sample3_wait: sample_valid got 0 expected 1"); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (n37 == 5) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sample4_wait: samples read got %0d expected 5", n37); end
    @(negedge clk); sample_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({axis_x, axis_y, axis_z, sample_valid, overrun_cnt} !== {16'h0605, 16'h0807, 16'h0309, 1'b1, 8'd2}) begin
      n_fail++; $display("FAIL same_cycle_accept: got %h %h %h v=%b ovr=%0d expected 0605 0807 0309 v=1 ovr=2",
                         axis_x, axis_y, axis_z, sample_valid, overrun_cnt);
    end
    @(negedge clk); sample_ready = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic        ok;
    int          base;
    int unsigned bad;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (spi_req && spi_addr == 6'h35) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read4_wait: no request to 35 seen"); end
    base = log_addr.size();
    @(negedge clk); enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!spi_req) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read4_finish: spi_req got 1 expected 0 within 30 cycles"); end
    bad = 0;
    repeat (30) begin @(posedge clk); #1; if (spi_req) bad++; end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL no_more_req: got %0d request cycles expected 0", bad); end
    n_checks++;
    if (log_addr.size() != base + 1 || log_addr[log_addr.size()-1] !== 6'h35) begin
      n_fail++; $display("FAIL read4_completed: got %0d transfers expected 1 to addr 35", log_addr.size() - base);
    end
    n_checks++;
    if ({axis_x, axis_y, axis_z, sample_valid, cfg_done, overrun_cnt} !== {16'h0605, 16'h0807, 16'h0309, 1'b1, 1'b0, 8'd2}) begin
      n_fail++; $display("FAIL drop_outputs: got %h %h %h v=%b cfg=%b ovr=%0d expected 0605 0807 0309 v=1 cfg=0 ovr=2",
                         axis_x, axis_y, axis_z, sample_valid, cfg_done, overrun_cnt);
    end
  endtask

  task automatic test_rst_mid_read();
    logic ok;
    int   base;
    base = log_addr.size();
    @(negedge clk); enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (cfg_done) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || log_addr.size() != base + 3 || log_addr[base] !== 6'h31 || log_data[base] !== 8'h0B) begin
      n_fail++; $display("FAIL reconfig: got cfg_done=%b first addr entries=%0d expected restart at 31/0b", cfg_done, log_addr.size() - base);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (spi_req && spi_addr == 6'h34) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL read3_wait: no request to 34 seen"); end
    @(negedge clk); rst = 1'b1; model_on = 1'b0;
    #1;
    n_checks++;
    if ({spi_req, axis_x, axis_y, axis_z, sample_valid, cfg_done, overrun_cnt, timeout_err} !== 60'h0) begin
      n_fail++; $display("FAIL async_rst: got req=%b %h %h %h v=%b cfg=%b ovr=%0d to=%b expected all 0",
                         spi_req, axis_x, axis_y, axis_z, sample_valid, cfg_done, overrun_cnt, timeout_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (spi_req !== 1'b0) begin n_fail++; $display("FAIL rst_release_req: got %b expected 0", spi_req); end
  endtask

  task automatic test_timeout();
    logic        ok;
    int unsigned hi;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_req) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || {spi_rw, spi_addr, spi_wdata} !== {1'b0, 6'h31, 8'h0B}) begin
      n_fail++; $display("FAIL restart_cfg_fmt: got req=%b rw=%b addr=%h data=%h expected req=1 rw=0 addr=31 data=0b",
                         spi_req, spi_rw, spi_addr, spi_wdata);
    end
    hi = ok ? 1 : 0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (!spi_req) break;
      hi++;
    end
    n_checks++;
    if (hi != 64) begin n_fail++; $display("FAIL timeout_len: got %0d request cycles expected 64", hi); end
    n_checks++;
    if ({timeout_err, cfg_done, spi_req} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_flags: got to=%b cfg=%b req=%b expected to=1 cfg=0 req=0", timeout_err, cfg_done, spi_req);
    end
    enable = 1'b0;
    hi = 0;
    repeat (5) begin @(negedge clk); if (spi_req) hi++; end
    n_checks++;
    if (hi != 0 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_idle: got %0d request cycles to=%b expected 0 and to=1", hi, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_sample();
    test_overrun();
    test_accept_same_cycle();
    test_enable_drop();
    test_rst_mid_read();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
